// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution engine.
// CONV_SAT_EN selects saturating narrowing; otherwise results wrap.
package conv_pkg;

  localparam int MODE_FIR    = 0;
  localparam int MODE_ENERGY = 1;
  localparam int NARROW_W    = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Round half up and shift, then fit into out_w bits (clamp or wrap).
  function automatic logic signed [NARROW_W-1:0] narrow(
    input logic signed [NARROW_W-1:0] acc,
    input int                         shift,
    input int                         out_w
  );
    logic signed [NARROW_W-1:0] v, one;
`ifdef CONV_SAT_EN
    logic signed [NARROW_W-1:0] hi, lo;
`endif
    one = {{(NARROW_W-1){1'b0}}, 1'b1};
    v   = acc;
    if (shift > 0) v = (v + (one <<< (shift - 1))) >>> shift;
`ifdef CONV_SAT_EN
    hi = (one <<< (out_w - 1)) - one;
    lo = -hi - one;
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
`else
    v = (v <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
`endif
    return v;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate; i_sq squares i_a instead of i_a*i_b.
// o_sum is the accumulator plus the current product, ready before the edge.
module conv_mac #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int ACC_W = 35
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_sq,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_sum
);
  localparam int M_W = (A_W > B_W) ? A_W : B_W;

  logic signed [M_W-1:0]   w_a, w_b;
  logic signed [2*M_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_a    = M_W'(i_a);
  assign w_b    = i_sq ? M_W'(i_a) : M_W'(i_b);
  assign w_prod = (2*M_W)'(w_a) * (2*M_W)'(w_b);
  assign o_sum  = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= o_sum;
  end
endmodule

// File: rtl/conv_stream_fir.sv
// Streaming FIR / windowed-energy engine: history, coefficient bank, FSM and one MAC.
// Narrowing saturates when CONV_SAT_EN is defined, wraps otherwise.
module conv_stream_fir
  import conv_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 14,
  parameter int MODE      = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        input_data,
  input  logic                     in_parity,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     coef_err,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         output_data,
  output logic                     parity,
  output logic                     busy
);
  localparam int IW    = $clog2(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int SHIFT = (MODE == MODE_ENERGY) ? 0 : OUT_SHIFT;
  localparam logic [COEF_W-1:0] COEF_UNITY = {{(COEF_W-1){1'b0}}, 1'b1} << OUT_SHIFT;

  state_t                       r_state, w_state_nxt;
  logic [TAPS-1:0][DATA_W-1:0]  r_hist;
  logic [TAPS-1:0][COEF_W-1:0]  r_coef;
  logic [IW-1:0]                r_idx;
  logic                         r_in_ready, r_out_valid, r_parity, r_coef_err;
  logic [OUT_W-1:0]             r_out;
  logic                         r_pend_vld;
  logic [IW-1:0]                r_pend_addr;
  logic [COEF_W-1:0]            r_pend_data;

  logic w_accept, w_last, w_hs_out, w_mac_en, w_coef_wr, w_coef_drop;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [NARROW_W-1:0] w_narrow;
  logic                       w_unused_hi;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last)   w_state_nxt = ST_OUT;
      ST_OUT:  if (w_hs_out) w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_hs_out    = 1'b0;
    w_mac_en    = 1'b0;
    w_coef_wr   = 1'b0;
    w_coef_drop = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept  = in_valid & r_in_ready;
        w_coef_wr = coef_we;
      end
      ST_MAC: begin
        w_mac_en    = 1'b1;
        w_last      = (r_idx == IW'(TAPS - 1));
        w_coef_drop = coef_we;
      end
      ST_OUT: begin
        w_hs_out    = r_out_valid & out_ready;
        w_coef_drop = coef_we;
      end
      default: ;
    endcase
  end

  conv_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk   (CLK),
    .rst   (RST),
    .i_clr (w_accept),
    .i_en  (w_mac_en),
    .i_sq  (MODE == MODE_ENERGY),
    .i_a   ($signed(r_hist[r_idx])),
    .i_b   ($signed(r_coef[r_idx])),
    .o_sum (w_sum)
  );

  assign w_narrow    = narrow(NARROW_W'(w_sum), SHIFT, OUT_W);
  assign w_unused_hi = ^w_narrow[NARROW_W-1:OUT_W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hist      <= '0;
      r_coef      <= '0;
      r_coef[0]   <= COEF_UNITY;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_parity    <= 1'b0;
      r_coef_err  <= 1'b0;
      r_out       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      r_in_ready <= (w_state_nxt == ST_IDLE);
      r_coef_err <= w_coef_drop;

      if (w_accept) begin
        r_hist   <= flush ? {{((TAPS-1)*DATA_W){1'b0}}, input_data}
                          : {r_hist[TAPS-2:0], input_data};
        r_parity <= in_parity;
        r_idx    <= '0;
      end else if (r_state == ST_IDLE && flush) begin
        r_hist <= '0;
      end

      if (w_mac_en) r_idx <= r_idx + IW'(1);

      if (w_last) begin
        r_out       <= w_narrow[OUT_W-1:0];
        r_out_valid <= 1'b1;
      end else if (w_hs_out) begin
        r_out_valid <= 1'b0;
      end

      // A write coinciding with an accept is parked so the sample in flight keeps the old bank.
      if (w_coef_wr) begin
        if (w_accept) begin
          r_pend_vld  <= 1'b1;
          r_pend_addr <= coef_addr;
          r_pend_data <= coef_data;
        end else begin
          r_coef[coef_addr] <= coef_data;
        end
      end
      if (w_hs_out && r_pend_vld) begin
        r_coef[r_pend_addr] <= r_pend_data;
        r_pend_vld          <= 1'b0;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign output_data = r_out;
  assign parity      = r_parity;
  assign coef_err    = r_coef_err;
  assign busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_conv_stream_fir.sv
// Scoreboard bench: FIR, energy/32-bit and energy/16-bit instances share one stimulus stream.
module tb_conv_stream_fir;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        in_valid = 0, in_parity = 0, coef_we = 0, flush = 0, out_ready = 1;
  logic [15:0] input_data = '0, coef_data = '0;
  logic [2:0]  coef_addr = '0;

  logic        ir_f, ir_e, ir_x, ce_f, ce_e, ce_x, ov_f, ov_e, ov_x;
  logic        par_f, par_e, par_x, busy_f, busy_e, busy_x;
  logic [31:0] od_f, od_e;
  logic [15:0] od_x;

  typedef struct {
    logic [31:0] fir;
    logic [31:0] e32;
    logic [15:0] e16;
    logic        par;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_hist[8];
  logic [15:0] m_coef[8];
  int checks = 0, fails = 0;

  always #5 CLK = ~CLK;

  conv_stream_fir u_fir (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_f), .input_data(input_data),
    .in_parity(in_parity), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(ce_f), .flush(flush), .out_valid(ov_f), .out_ready(out_ready),
    .output_data(od_f), .parity(par_f), .busy(busy_f));

  conv_stream_fir #(.MODE(1)) u_e32 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_e), .input_data(input_data),
    .in_parity(in_parity), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(ce_e), .flush(flush), .out_valid(ov_e), .out_ready(out_ready),
    .output_data(od_e), .parity(par_e), .busy(busy_e));

  conv_stream_fir #(.MODE(1), .OUT_W(16)) u_e16 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_x), .input_data(input_data),
    .in_parity(in_parity), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(ce_x), .flush(flush), .out_valid(ov_x), .out_ready(out_ready),
    .output_data(od_x), .parity(par_x), .busy(busy_x));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint narrow_m(input longint v, input int w);
`ifdef CONV_SAT_EN
    longint hi;
    hi = (longint'(1) <<< (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
`else
    return (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_hist[i] = '0;
      m_coef[i] = '0;
    end
    m_coef[0] = 16'h4000;
    sb.delete();
  endtask

  task automatic model_accept(input logic [15:0] x, input logic par, input logic fl);
    longint fir, en;
    exp_t e;
    if (fl) for (int i = 0; i < 8; i++) m_hist[i] = '0;
    for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    fir = 0;
    en  = 0;
    for (int i = 0; i < 8; i++) begin
      fir += longint'($signed(m_hist[i])) * longint'($signed(m_coef[i]));
      en  += longint'($signed(m_hist[i])) * longint'($signed(m_hist[i]));
    end
    fir   = (fir + 8192) >>> 14;
    e.fir = 32'(narrow_m(fir, 32));
    e.e32 = 32'(narrow_m(en, 32));
    e.e16 = 16'(narrow_m(en, 16));
    e.par = par;
    sb.push_back(e);
  endtask

  // Compare on the cycle before each output handshake edge.
  always @(negedge CLK) begin
    if (!RST && ov_f && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("fir_out", od_f, e.fir);
        chk("e32_out", od_e, e.e32);
        chk("e16_out", od_x, e.e16);
        chk("parity", par_f, e.par);
        chk("lockstep", {ov_e, ov_x}, 2'b11);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic par, input logic fl,
                      input logic cw, input logic [2:0] ca, input logic [15:0] cd);
    int n;
    n = 0;
    while (!ir_f && n < 50) begin @(posedge CLK); #1; n++; end
    if (!ir_f) begin chk("in_ready_timeout", 0, 1); return; end
    in_valid = 1; input_data = x; in_parity = par; flush = fl;
    coef_we = cw; coef_addr = ca; coef_data = cd;
    @(posedge CLK);
    model_accept(x, par, fl);
    if (cw) m_coef[ca] = cd;
    #1;
    in_valid = 0; flush = 0; coef_we = 0;
    n = 0;
    while (!ov_f && n < 40) begin @(posedge CLK); #1; n++; end
    chk("latency", n, 8);
    if (out_ready) begin
      n = 0;
      while (busy_f && n < 10) begin @(posedge CLK); #1; n++; end
      chk("back_to_idle", busy_f, 0);
    end
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
    coef_we = 1; coef_addr = a; coef_data = d;
    @(posedge CLK); #1;
    coef_we = 0;
    m_coef[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        err_seen;
    model_reset();
    #12;
    chk("rst_in_ready", ir_f, 0);
    chk("rst_out_valid", ov_f, 0);
    chk("rst_output", od_f, 0);
    chk("rst_parity", par_f, 0);
    chk("rst_coef_err", ce_f, 0);
    chk("rst_busy", busy_f, 0);
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;
    chk("in_ready_after_rst", ir_f, 1);

    // identity filter straight out of reset
    send(16'h0123, 1, 0, 0, 0, 0);
    send(16'hFFFF, 0, 0, 0, 0, 0);

    // moving sum over a clean window
    for (int i = 0; i < 8; i++) wr_coef(3'(i), 16'h4000);
    for (int i = 1; i <= 8; i++) send(16'(i), 1'(i), (i == 1), 0, 0, 0);

    // coefficient write on the accept edge only affects the following sample
    send(16'd9, 1, 0, 1, 3'd0, 16'h8000);
    send(16'd0, 0, 0, 0, 0, 0);

    // energy: 3 then -4 from a flushed window
    send(16'd3, 0, 1, 0, 0, 0);
    send(16'hFFFC, 1, 0, 0, 0, 0);

    // standalone flush then overflow of the 16-bit energy output
    flush = 1; @(posedge CLK); #1; flush = 0;
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
    send(16'h7FFF, 1, 0, 0, 0, 0);

    // backpressure with ignored input and dropped coefficient writes
    out_ready = 0;
    send(16'h0005, 1, 0, 0, 0, 0);
    held = od_f;
    err_seen = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; input_data = 16'h5555; coef_we = 1; coef_addr = 3'd1; coef_data = 16'h1234;
      @(posedge CLK); #1;
      chk("bp_hold", od_f, held);
      chk("bp_in_ready", ir_f, 0);
      chk("bp_valid", ov_f, 1);
      err_seen |= ce_f;
    end
    chk("bp_coef_err", err_seen, 1);
    in_valid = 0; coef_we = 0; out_ready = 1;
    @(posedge CLK); #1;
    chk("in_ready_after_hs", ir_f, 1);
    send(16'h0006, 0, 0, 0, 0, 0);

    // asynchronous reset during the third MAC cycle
    in_valid = 1; input_data = 16'h0077; in_parity = 1;
    @(posedge CLK); #1; in_valid = 0;
    @(posedge CLK); @(posedge CLK); #2;
    RST = 1;
    #1;
    chk("mid_rst_output", od_f, 0);
    chk("mid_rst_valid", ov_f, 0);
    chk("mid_rst_busy", busy_f, 0);
    chk("mid_rst_in_ready", ir_f, 0);
    chk("mid_rst_parity", par_f, 0);
    model_reset();
    @(negedge CLK); RST = 0;
    err_seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge CLK); #1; err_seen |= ov_f; end
    chk("no_partial_result", err_seen, 0);
    send(16'h0042, 0, 0, 0, 0, 0);

    repeat (3) @(posedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/conv_stream_fir.md
Name: conv_stream_fir

Overview:
- Parametrised streaming convolution engine for the heart-sound segmentation datapath; successor to the fixed single-mode convolution block.
- Holds a TAPS-deep sample history and a writable coefficient bank. It computes one output per accepted sample with a single time-multiplexed MAC.
- Adds valid/ready handshakes, a runtime coefficient load, an energy (sum-of-squares) mode, rounding and an optional saturation stage.
- Sits between the sample source (ADC/DMA buffer) and the envelope/segmentation logic on the RISC-V bus side.

Parameters:
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed coefficient width
- TAPS, 8, window length, power of two, 2..64
- OUT_W, 32, signed output width
- OUT_SHIFT, 14, arithmetic right shift applied in FIR mode; unity coefficient = 1<<OUT_SHIFT
- MODE, 0, 0 = FIR convolution, 1 = windowed energy (sum of x^2, coefficients ignored, no shift)

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- input_data  in  DATA_W  signed sample
- in_parity  in  1  tag travelling with the sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  log2(TAPS)  tap index
- coef_data  in  COEF_W  coefficient value
- coef_err  out  1  one-cycle pulse: write dropped because block busy
- flush  in  1  clear sample history (IDLE only)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- output_data  out  OUT_W  signed result
- parity  out  1  tag of the sample that produced output_data
- busy  out  1  state != IDLE

Behaviour:
- One clock (CLK); reset RST is asynchronous and active-high.
- Reset values:
  - in_ready=0, out_valid=0, output_data=0, parity=0, coef_err=0, busy=0.
  - History all zero; state=IDLE; acc=0; idx=0.
  - Coefficients: tap0=1<<OUT_SHIFT, all others 0 (identity filter).
  - in_ready becomes 1 on the first edge after RST deasserts.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: shift input_data into hist[0] (oldest drops out of hist[TAPS-1]); latch in_parity; acc<=0; idx<=0; in_ready<=0; go to MAC.
- MAC, exactly TAPS cycles:
  - FIR: acc += hist[idx]*coef[idx]. Energy: acc += hist[idx]^2.
  - idx increments each cycle.
  - On the last cycle the final sum is post-processed into output_data; out_valid<=1; go to OUT.
- Latency: out_valid rises exactly TAPS edges after the accepting edge. Throughput is one sample per TAPS+2 cycles.
- OUT:
  - output_data and parity held stable while out_valid=1.
  - On out_valid&out_ready: out_valid<=0, in_ready<=1, go to IDLE.
  - in_valid is ignored outside IDLE.
- Arithmetic:
  - Accumulator width ACC_W = DATA_W+COEF_W+log2(TAPS), signed, full precision, no internal overflow.
  - FIR post-processing: (acc + (1<<(OUT_SHIFT-1))) >>> OUT_SHIFT (round half up; no rounding term when OUT_SHIFT=0).
  - Energy post-processing: acc unshifted.
  - The result is then narrowed to OUT_W per the Optional Feature.
- Coefficient writes:
  - Accepted only in IDLE, registered on the edge.
  - coef_we in MAC/OUT: write dropped, coef_err pulses for one cycle.
  - A write in IDLE on the same edge as an input handshake is applied, but the new coefficient is used only from the next sample on.
- flush:
  - In IDLE: zeroes the history. flush together with a handshake gives history = {input_data, 0, ...}.
  - Ignored in other states.
- Reset mid-operation: all state is discarded immediately; no partial result is emitted.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: the narrowed result clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the low OUT_W bits are taken (two's-complement wrap).
- Both builds are identical when the value fits.

Decomposition:
- Package conv_pkg:
  - mode constants MODE_FIR=0, MODE_ENERGY=1
  - state enumeration (IDLE/MAC/OUT)
  - acc_width function
  - narrow (round/shift/saturate) function
- Sub-module conv_mac: registered signed multiply-accumulate with clear, enable and a square-select input. It is instantiated once. History, coefficient bank and FSM stay in the top.

Test Plan:
- Identity after reset: MODE=0, feed 0x0123, then 0xFFFF. Expect output_data=0x00000123, then 0xFFFFFFFF. out_valid 8 edges after each accept; parity follows in_parity 1, 0.
- Moving sum: write all 8 coefs 0x4000, feed 1..8. Expect 1, 3, 6, 10, 15, 21, 28, 36.
- Energy: MODE=1, feed 3, then -4 (0xFFFC). Expect 9, then 25.
- Narrowing: MODE=1, OUT_W=16, feed 0x7FFF. Expect 0x7FFF with CONV_SAT_EN, 0x0001 without.
- Backpressure/protocol: out_ready=0 for 5 cycles with in_valid=1 and coef_we=1. Expect output_data stable, in_ready=0, coef_err pulses, coefs unchanged. Then out_ready=1: in_ready high next cycle.
- Reset mid-MAC: pulse RST on the 3rd MAC cycle. Expect all outputs 0 asynchronously and no out_valid. Next sample 0x0042 gives 0x00000042 (identity coefs, clean history).
